aes_key_sched_reader: RTL and testbench

AES_KEY_SCHED_READER -- requirements
Module: aes_key_sched_reader

---
 rtl/aes_key_sched_reader_if.sv | 46 ++++
 rtl/aes_key_sched_reader.sv | 175 +++++++++++++++++
 tb/tb_aes_key_sched_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_reader_if.sv
// Bus bundle for the AES round-key reader: host key-load handshake,
// key-expansion load/read side and round-key stream towards the cipher core.
interface aes_key_sched_reader_if;
   // Host key load
   logic [255:0] host_key;
   logic [1:0]   host_ksize;
   logic         host_kvalid;
   logic         host_kready;
   // Key-expansion load side
   logic [255:0] CipherKey;
   logic         k_ready;
   logic [3:0]   Nk;
   // Key-expansion read side
   logic [3:0]   Addr;
   logic [127:0] ex_key;
   logic         ex_valid;
   // Round-key stream control
   logic         rk_start;
   logic         rk_dir;
   logic         rk_abort;
   // Round-key stream output
   logic [127:0] rk_out;
   logic         rk_valid;
   logic         rk_ready;
   logic [3:0]   rk_round;
   logic         rk_last;
   // Status
   logic         busy;
   logic         err;

   // Environment side: host, key expansion and round-key consumer
   modport master (
      output host_key, host_ksize, host_kvalid, ex_key, ex_valid,
             rk_start, rk_dir, rk_abort, rk_ready,
      input  host_kready, CipherKey, k_ready, Nk, Addr,
             rk_out, rk_valid, rk_round, rk_last, busy, err
   );

   // Reader side
   modport slave (
      input  host_key, host_ksize, host_kvalid, ex_key, ex_valid,
             rk_start, rk_dir, rk_abort, rk_ready,
      output host_kready, CipherKey, k_ready, Nk, Addr,
             rk_out, rk_valid, rk_round, rk_last, busy, err
   );
endinterface

// File: rtl/aes_key_sched_reader.sv
// AES round-key reader: accepts a cipher key from the host, hands it to the
// key-expansion block for one cycle, then streams round keys 0..Nr (forward)
// or Nr..0 (reverse) to the cipher core with a valid/ready handshake.
module aes_key_sched_reader (
   input logic                    clk,
   input logic                    rst_n,
   aes_key_sched_reader_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, LOAD, PRIME, READY, FETCH, HOLD} state_e;

   state_e         state_q, state_d;
   logic [255:0]   cipher_key_q, cipher_key_d;
   logic [3:0]     nk_q, nk_d;
   logic [3:0]     nr_q, nr_d;
   logic           k_ready_q, k_ready_d;
   logic [3:0]     addr_q, addr_d;       // also serves as the round counter
   logic [127:0]   rk_out_q, rk_out_d;
   logic           rk_valid_q, rk_valid_d;
   logic [3:0]     rk_round_q, rk_round_d;
   logic           rk_last_q, rk_last_d;
   logic           err_q, err_d;
   logic           dir_q, dir_d;
   logic           first_q, first_d;     // first cycle in PRIME/FETCH: ex_valid not yet trustworthy

   logic           load_acc;
   logic [3:0]     end_round;

   assign bus.host_kready = (state_q == IDLE) || (state_q == READY);
   assign bus.busy        = (state_q == LOAD) || (state_q == PRIME) ||
                            (state_q == FETCH) || (state_q == HOLD);

   assign load_acc  = bus.host_kvalid & bus.host_kready;
   assign end_round = dir_q ? 4'd0 : nr_q;

   assign bus.CipherKey = cipher_key_q;
   assign bus.Nk        = nk_q;
   assign bus.k_ready   = k_ready_q;
   assign bus.Addr      = addr_q;
   assign bus.rk_out    = rk_out_q;
   assign bus.rk_valid  = rk_valid_q;
   assign bus.rk_round  = rk_round_q;
   assign bus.rk_last   = rk_last_q;
   assign bus.err       = err_q;

   // Next-state and next-output decode for the whole reader.
   always_comb begin
      // NOTE: every _d is defaulted to its _q first so no path leaves a signal
      // unassigned; a missing default here would infer a latch.
      state_d      = state_q;
      cipher_key_d = cipher_key_q;
      nk_d         = nk_q;
      nr_d         = nr_q;
      k_ready_d    = k_ready_q;
      addr_d       = addr_q;
      rk_out_d     = rk_out_q;
      rk_valid_d   = rk_valid_q;
      rk_round_d   = rk_round_q;
      rk_last_d    = rk_last_q;
      err_d        = err_q;
      dir_d        = dir_q;
      first_d      = first_q;

      case (state_q)
         IDLE, READY: begin
            if (load_acc) begin
               // A key load wins over rk_start in READY
               if (bus.host_ksize == 2'd3) begin
                  err_d = 1'b1;
               end else begin
                  cipher_key_d = bus.host_key;
                  case (bus.host_ksize)
                     2'd0:    begin nk_d = 4'd4; nr_d = 4'd10; end
                     2'd1:    begin nk_d = 4'd6; nr_d = 4'd12; end
                     default: begin nk_d = 4'd8; nr_d = 4'd14; end
                  endcase
                  err_d     = 1'b0;
                  k_ready_d = 1'b1;
                  state_d   = LOAD;
               end
            end else if ((state_q == READY) && bus.rk_start) begin
               dir_d   = bus.rk_dir;
               addr_d  = bus.rk_dir ? nr_q : 4'd0;
               first_d = 1'b1;
               state_d = FETCH;
            end
         end
         LOAD: begin
            // Key expansion has captured the key; stop exposing it
            k_ready_d    = 1'b0;
            cipher_key_d = '0;
            nk_d         = '0;
            addr_d       = '0;
            first_d      = 1'b1;
            state_d      = PRIME;
         end
         PRIME: begin
            if (first_q)           first_d = 1'b0;
            else if (bus.ex_valid) state_d = READY;
         end
         FETCH: begin
            if (bus.rk_abort) begin
               rk_valid_d = 1'b0;
               rk_last_d  = 1'b0;
               state_d    = READY;
            end else if (first_q) begin
               first_d = 1'b0;
            end else if (bus.ex_valid) begin
               rk_out_d   = bus.ex_key;
               rk_round_d = addr_q;
               rk_last_d  = (addr_q == end_round);
               rk_valid_d = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (bus.rk_abort) begin
               rk_valid_d = 1'b0;
               rk_last_d  = 1'b0;
               state_d    = READY;
            end else if (bus.rk_ready) begin
               rk_valid_d = 1'b0;
               rk_last_d  = 1'b0;
               if (rk_last_q) begin
                  state_d = READY;
               end else begin
                  // Terminal key ends the walk, so Addr never leaves 0..Nr
                  addr_d  = dir_q ? (addr_q - 4'd1) : (addr_q + 4'd1);
                  first_d = 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the 256-bit key register is cleared on reset on purpose: a reset
         // must discard the loaded key, so it is not left as reset-free storage.
         state_q      <= IDLE;
         cipher_key_q <= '0;
         nk_q         <= '0;
         nr_q         <= '0;
         k_ready_q    <= 1'b0;
         addr_q       <= '0;
         rk_out_q     <= '0;
         rk_valid_q   <= 1'b0;
         rk_round_q   <= '0;
         rk_last_q    <= 1'b0;
         err_q        <= 1'b0;
         dir_q        <= 1'b0;
         first_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge regardless of statement order.
         state_q      <= state_d;
         cipher_key_q <= cipher_key_d;
         nk_q         <= nk_d;
         nr_q         <= nr_d;
         k_ready_q    <= k_ready_d;
         addr_q       <= addr_d;
         rk_out_q     <= rk_out_d;
         rk_valid_q   <= rk_valid_d;
         rk_round_q   <= rk_round_d;
         rk_last_q    <= rk_last_d;
         err_q        <= err_d;
         dir_q        <= dir_d;
         first_q      <= first_d;
      end
   end

endmodule

// File: tb/tb_aes_key_sched_reader.sv
// Directed bench for aes_key_sched_reader. The key-expansion block is modelled
// as a pattern keyed on Addr so every round key identifies its own round.
module tb_aes_key_sched_reader;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   aes_key_sched_reader_if bus ();

   aes_key_sched_reader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Key-expansion stand-in: round key r is {8{12'hABC, r}}
   assign bus.ex_key = {8{12'hABC, bus.Addr}};

   function automatic logic [127:0] key_of(input logic [3:0] r);
      return {8{12'hABC, r}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a key and follow it through LOAD and PRIME into READY.
   task automatic do_load(input logic [255:0] key, input logic [1:0] ks,
                          input logic [3:0] exp_nk, input logic with_start);
      int n;
      bus.host_key    = key;
      bus.host_ksize  = ks;
      bus.host_kvalid = 1'b1;
      bus.rk_start    = with_start;
      bus.rk_dir      = 1'b0;
      tick();
      bus.host_kvalid = 1'b0;
      bus.rk_start    = 1'b0;
      total++; if (bus.k_ready !== 1'b1) $display("FAIL load_k_ready got=%b want=1", bus.k_ready); else passed++;
      total++; if (bus.CipherKey !== key) $display("FAIL load_cipherkey got=%h want=%h", bus.CipherKey, key); else passed++;
      total++; if (bus.Nk !== exp_nk) $display("FAIL load_nk got=%0d want=%0d", bus.Nk, exp_nk); else passed++;
      total++; if (bus.err !== 1'b0) $display("FAIL load_err got=%b want=0", bus.err); else passed++;
      total++; if ({bus.busy, bus.host_kready} !== 2'b10) $display("FAIL load_busy got=%b want=10", {bus.busy, bus.host_kready}); else passed++;
      tick();
      total++; if (bus.k_ready !== 1'b0) $display("FAIL prime_k_ready got=%b want=0", bus.k_ready); else passed++;
      total++; if (bus.CipherKey !== 256'd0) $display("FAIL prime_cipherkey got=%h want=0", bus.CipherKey); else passed++;
      total++; if (bus.Nk !== 4'd0) $display("FAIL prime_nk got=%0d want=0", bus.Nk); else passed++;
      total++; if (bus.Addr !== 4'd0) $display("FAIL prime_addr got=%0d want=0", bus.Addr); else passed++;
      n = 0;
      while (bus.host_kready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total++; if (bus.host_kready !== 1'b1) $display("FAIL prime_to_ready timeout host_kready=%b want=1", bus.host_kready); else passed++;
   endtask

   // Issue rk_start and consume round keys, optionally stalling or aborting at a round.
   task automatic run_seq(input logic dir, input int nr, input int stall_round, input int abort_round);
      int exp, endr, keys, n;
      logic finished, aborted, addr_bad;
      logic [127:0] held_out;
      logic [3:0]   held_round;
      exp = dir ? nr : 0;
      endr = dir ? 0 : nr;
      keys = 0; n = 0;
      finished = 1'b0; aborted = 1'b0; addr_bad = 1'b0;
      bus.rk_dir   = dir;
      bus.rk_ready = 1'b1;
      bus.rk_start = 1'b1;
      tick();
      bus.rk_start = 1'b0;
      total++; if (bus.busy !== 1'b1) $display("FAIL seq_start_busy got=%b want=1", bus.busy); else passed++;
      while (!finished && n < 400) begin
         tick();
         n++;
         if (int'(bus.Addr) > nr) addr_bad = 1'b1;
         if (bus.rk_valid === 1'b1) begin
            keys++;
            total++; if (bus.rk_round !== 4'(exp)) $display("FAIL seq_round got=%0d want=%0d", bus.rk_round, exp); else passed++;
            total++; if (bus.rk_out !== key_of(4'(exp))) $display("FAIL seq_key r=%0d got=%h want=%h", exp, bus.rk_out, key_of(4'(exp))); else passed++;
            total++; if (bus.rk_last !== (exp == endr)) $display("FAIL seq_last r=%0d got=%b want=%b", exp, bus.rk_last, (exp == endr)); else passed++;
            if (exp == abort_round) begin
               bus.rk_abort = 1'b1;
               tick();
               bus.rk_abort = 1'b0;
               total++; if (bus.host_kready !== 1'b1) $display("FAIL abort_ready got=%b want=1", bus.host_kready); else passed++;
               total++; if (bus.rk_valid !== 1'b0) $display("FAIL abort_valid got=%b want=0", bus.rk_valid); else passed++;
               total++; if (bus.rk_last !== 1'b0) $display("FAIL abort_last got=%b want=0", bus.rk_last); else passed++;
               aborted  = 1'b1;
               finished = 1'b1;
            end else begin
               if (exp == stall_round) begin
                  bus.rk_ready = 1'b0;
                  held_out     = bus.rk_out;
                  held_round   = bus.rk_round;
                  repeat (3) begin
                     tick();
                     total++; if (bus.rk_valid !== 1'b1) $display("FAIL stall_valid got=%b want=1", bus.rk_valid); else passed++;
                     total++; if (bus.rk_out !== held_out) $display("FAIL stall_key got=%h want=%h", bus.rk_out, held_out); else passed++;
                     total++; if (bus.rk_round !== held_round) $display("FAIL stall_round got=%0d want=%0d", bus.rk_round, held_round); else passed++;
                  end
                  bus.rk_ready = 1'b1;
               end
               if (exp == endr) finished = 1'b1;
               else exp = dir ? exp - 1 : exp + 1;
            end
         end
      end
      total++; if (!finished) $display("FAIL seq_timeout keys=%0d want=%0d", keys, nr + 1); else passed++;
      if (!aborted && finished) begin
         tick();
         total++; if ({bus.host_kready, bus.rk_valid} !== 2'b10) $display("FAIL seq_end_ready got=%b want=10", {bus.host_kready, bus.rk_valid}); else passed++;
         total++; if (keys != nr + 1) $display("FAIL seq_key_count got=%0d want=%0d", keys, nr + 1); else passed++;
      end
      total++; if (addr_bad) $display("FAIL seq_addr_range Addr exceeded %0d", nr); else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      total++; if (bus.host_kready !== 1'b1) $display("FAIL rst_host_kready got=%b want=1", bus.host_kready); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.busy); else passed++;
      total++; if (bus.CipherKey !== 256'd0 || bus.Nk !== 4'd0 || bus.k_ready !== 1'b0)
         $display("FAIL rst_load_side got=%h/%0d/%b want=0/0/0", bus.CipherKey, bus.Nk, bus.k_ready); else passed++;
      total++; if (bus.Addr !== 4'd0 || bus.rk_out !== 128'd0 || bus.rk_round !== 4'd0)
         $display("FAIL rst_stream got=%0d/%h/%0d want=0/0/0", bus.Addr, bus.rk_out, bus.rk_round); else passed++;
      total++; if ({bus.rk_valid, bus.rk_last, bus.err} !== 3'b000)
         $display("FAIL rst_flags got=%b want=000", {bus.rk_valid, bus.rk_last, bus.err}); else passed++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_128();
      do_load({128'd0, 128'hFFEEDDBBCCAA99887766554433221100}, 2'd0, 4'd4, 1'b0);
   endtask

   task automatic test_forward_128();
      run_seq(1'b0, 10, -1, -1);
   endtask

   task automatic test_illegal_size();
      bus.host_key    = {256{1'b1}};
      bus.host_ksize  = 2'd3;
      bus.host_kvalid = 1'b1;
      tick();
      bus.host_kvalid = 1'b0;
      total++; if (bus.err !== 1'b1) $display("FAIL illegal_err got=%b want=1", bus.err); else passed++;
      total++; if (bus.k_ready !== 1'b0) $display("FAIL illegal_k_ready got=%b want=0", bus.k_ready); else passed++;
      total++; if ({bus.host_kready, bus.busy} !== 2'b10) $display("FAIL illegal_state got=%b want=10", {bus.host_kready, bus.busy}); else passed++;
      total++; if (bus.CipherKey !== 256'd0 || bus.Nk !== 4'd0) $display("FAIL illegal_key got=%h/%0d want=0/0", bus.CipherKey, bus.Nk); else passed++;
      tick();
      total++; if ({bus.err, bus.host_kready, bus.k_ready} !== 3'b110) $display("FAIL illegal_sticky got=%b want=110", {bus.err, bus.host_kready, bus.k_ready}); else passed++;
      // Legal 256-bit load with rk_start asserted alongside: the load must win and clear err
      do_load(256'h0F1E2D3C4B5A69788796A5B4C3D2E1F00112233445566778899AABBCCDDEEFF, 2'd2, 4'd8, 1'b1);
   endtask

   task automatic test_reverse_256_stall();
      run_seq(1'b1, 14, 7, -1);
   endtask

   task automatic test_abort();
      run_seq(1'b0, 14, -1, 5);
      run_seq(1'b0, 14, -1, -1);
   endtask

   task automatic test_reset_mid_fetch();
      logic saw_valid, saw_busy;
      bus.rk_dir   = 1'b1;
      bus.rk_start = 1'b1;
      tick();
      bus.rk_start = 1'b0;
      total++; if ({bus.busy, bus.Addr} !== {1'b1, 4'd14}) $display("FAIL midrst_fetch got=%b/%0d want=1/14", bus.busy, bus.Addr); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({bus.host_kready, bus.busy} !== 2'b10) $display("FAIL midrst_state got=%b want=10", {bus.host_kready, bus.busy}); else passed++;
      total++; if (bus.Addr !== 4'd0 || bus.rk_round !== 4'd0 || bus.rk_out !== 128'd0)
         $display("FAIL midrst_stream got=%0d/%0d/%h want=0/0/0", bus.Addr, bus.rk_round, bus.rk_out); else passed++;
      total++; if ({bus.rk_valid, bus.rk_last, bus.k_ready, bus.err} !== 4'b0000)
         $display("FAIL midrst_flags got=%b want=0000", {bus.rk_valid, bus.rk_last, bus.k_ready, bus.err}); else passed++;
      tick();
      rst_n = 1'b1;
      tick();
      bus.rk_dir   = 1'b0;
      bus.rk_start = 1'b1;
      tick();
      bus.rk_start = 1'b0;
      saw_valid = 1'b0;
      saw_busy  = 1'b0;
      repeat (20) begin
         if (bus.rk_valid === 1'b1) saw_valid = 1'b1;
         if (bus.busy === 1'b1) saw_busy = 1'b1;
         tick();
      end
      total++; if (saw_valid !== 1'b0) $display("FAIL midrst_no_key got=%b want=0", saw_valid); else passed++;
      total++; if (saw_busy !== 1'b0) $display("FAIL midrst_no_busy got=%b want=0", saw_busy); else passed++;
   endtask

   initial begin
      passed          = 0;
      total           = 0;
      bus.host_key    = '0;
      bus.host_ksize  = 2'd0;
      bus.host_kvalid = 1'b0;
      bus.ex_valid    = 1'b1;
      bus.rk_start    = 1'b0;
      bus.rk_dir      = 1'b0;
      bus.rk_abort    = 1'b0;
      bus.rk_ready    = 1'b1;
      test_reset();
      test_load_128();
      test_forward_128();
      test_illegal_size();
      test_reverse_256_stall();
      test_abort();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
